// File: rtl/ips2l_pcie_dma_cpld_split_sched.sv
// ============================================================================
// ips2l_pcie_dma_cpld_split_sched : splits one MRd into MPS-bounded completion
// chunks and sequences them through the BAR-RAM completion read controller.
// Revision 1.0
// ============================================================================
`default_nettype none

module ips2l_pcie_dma_cpld_split_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [63:0] i_req_addr,
   input  logic [9:0]  i_req_length,
   input  logic [7:0]  i_req_tag,
   input  logic [2:0]  i_max_payload,
   output logic        o_rd_en,
   output logic [9:0]  o_rd_length,
   output logic [63:0] o_rd_addr,
   output logic [11:0] o_cpl_byte_count,
   output logic [6:0]  o_cpl_lower_addr,
   output logic [7:0]  o_cpl_tag,
   input  logic        i_gen_tlp_start,
   input  logic        i_last_data,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CALC       = 3'd1,
      S_ISSUE      = 3'd2,
      S_WAIT_START = 3'd3,
      S_WAIT_LAST  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [63:0] r_addr;
   logic [10:0] r_rem_dw;
   logic [10:0] r_mps_dw;
   logic [7:0]  r_tag;
   logic [10:0] r_len;
   logic [63:0] r_rd_addr;
   logic [11:0] r_byte_count;
   logic [6:0]  r_lower_addr;
   logic        r_ready;
   logic        r_rd_en;
   logic        r_done;

   logic        w_accept;
   logic [2:0]  w_mps_code;
   logic [10:0] w_mps_dw;
   logic [10:0] w_offs_dw;
   logic [10:0] w_dist_dw;
   logic [10:0] w_len;
   logic [10:0] w_rem_nxt;
   logic        w_last_hit;

   // r_ready is only set once the state register is IDLE, so it alone qualifies acceptance
   assign w_accept   = i_req_valid & r_ready;
   assign w_mps_code = (i_max_payload > 3'd5) ? 3'd5 : i_max_payload;
   assign w_mps_dw   = 11'd32 << w_mps_code;
   assign w_offs_dw  = {1'b0, r_addr[11:2]} & (r_mps_dw - 11'd1);
   assign w_dist_dw  = r_mps_dw - w_offs_dw;
   assign w_len      = (r_rem_dw < w_dist_dw) ? r_rem_dw : w_dist_dw;
   assign w_rem_nxt  = r_rem_dw - r_len;
   assign w_last_hit = (r_state == S_WAIT_LAST) & i_last_data;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:       if (w_accept) w_state_nxt = S_CALC;
         S_CALC:       w_state_nxt = S_ISSUE;
         S_ISSUE:      w_state_nxt = S_WAIT_START;
         S_WAIT_START: if (i_gen_tlp_start) w_state_nxt = S_WAIT_LAST;
         S_WAIT_LAST:  if (i_last_data) w_state_nxt = (w_rem_nxt == 11'd0) ? S_IDLE : S_CALC;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == S_IDLE);
         r_rd_en <= (r_state == S_CALC);
         r_done  <= w_last_hit & (w_rem_nxt == 11'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= 64'd0;
         r_rem_dw     <= 11'd0;
         r_mps_dw     <= 11'd0;
         r_tag        <= 8'd0;
         r_len        <= 11'd0;
         r_rd_addr    <= 64'd0;
         r_byte_count <= 12'd0;
         r_lower_addr <= 7'd0;
      end else begin
         if ((r_state == S_IDLE) && w_accept) begin
            r_addr   <= i_req_addr & ~64'd3;
            r_rem_dw <= (i_req_length == 10'd0) ? 11'd1024 : {1'b0, i_req_length};
            r_tag    <= i_req_tag;
            r_mps_dw <= w_mps_dw;
         end
         if (r_state == S_CALC) begin
            r_len        <= w_len;
            r_rd_addr    <= r_addr;
            // 1024 DW remaining truncates to 0, the encoding for 4096 bytes
            r_byte_count <= {r_rem_dw[9:0], 2'b00};
            r_lower_addr <= r_addr[6:0];
         end
         if (w_last_hit) begin
            r_addr   <= r_addr + {51'd0, r_len, 2'b00};
            r_rem_dw <= w_rem_nxt;
         end
      end
   end

   assign o_req_ready      = r_ready;
   assign o_rd_en          = r_rd_en;
   assign o_rd_length      = r_len[9:0];
   assign o_rd_addr        = r_rd_addr;
   assign o_cpl_byte_count = r_byte_count;
   assign o_cpl_lower_addr = r_lower_addr;
   assign o_cpl_tag        = r_tag;
   assign o_busy           = (r_state != S_IDLE);
   assign o_done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ips2l_pcie_dma_cpld_split_sched.sv
// ============================================================================
// tb_ips2l_pcie_dma_cpld_split_sched : directed bench with a byte-level model
// of the completion split and a per-cycle output comparator.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ips2l_pcie_dma_cpld_split_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [63:0] i_req_addr = 64'd0;
   logic [9:0]  i_req_length = 10'd0;
   logic [7:0]  i_req_tag = 8'd0;
   logic [2:0]  i_max_payload = 3'd0;
   logic        o_rd_en;
   logic [9:0]  o_rd_length;
   logic [63:0] o_rd_addr;
   logic [11:0] o_cpl_byte_count;
   logic [6:0]  o_cpl_lower_addr;
   logic [7:0]  o_cpl_tag;
   logic        i_gen_tlp_start = 1'b0;
   logic        i_last_data = 1'b0;
   logic        o_busy;
   logic        o_done;

   always #5 clk = ~clk;

   ips2l_pcie_dma_cpld_split_sched dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .i_req_addr       (i_req_addr),
      .i_req_length     (i_req_length),
      .i_req_tag        (i_req_tag),
      .i_max_payload    (i_max_payload),
      .o_rd_en          (o_rd_en),
      .o_rd_length      (o_rd_length),
      .o_rd_addr        (o_rd_addr),
      .o_cpl_byte_count (o_cpl_byte_count),
      .o_cpl_lower_addr (o_cpl_lower_addr),
      .o_cpl_tag        (o_cpl_tag),
      .i_gen_tlp_start  (i_gen_tlp_start),
      .i_last_data      (i_last_data),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   typedef struct packed {
      logic [9:0]  len;
      logic [63:0] addr;
      logic [11:0] bc;
      logic [6:0]  la;
   } chunk_t;

   localparam int NEVER = 1 << 30;

   chunk_t      mq[$];
   chunk_t      exp_q[$];
   chunk_t      cc;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          exp_rd_cyc = -1;
   int          exp_done_cyc = -1;
   int          acc_cyc = -1;
   int          end_cyc = -1;
   bit          chk_hs = 1'b0;
   bit          exp_busy;
   logic [7:0]  cur_tag = 8'd0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Byte-level model: each chunk runs to the next MPS-aligned byte address or the end of the request
   task automatic build(input logic [63:0] a, input logic [9:0] l, input logic [2:0] code);
      longint unsigned addr_b;
      int              rem_b;
      int              mps_b;
      int              room;
      int              cb;
      chunk_t          ch;
      addr_b = a & ~64'd3;
      rem_b  = ((l == 10'd0) ? 1024 : int'(l)) * 4;
      mps_b  = 128 << ((code > 3'd5) ? 5 : int'(code));
      mq.delete();
      while (rem_b > 0) begin
         room    = mps_b - int'(addr_b % longint'(mps_b));
         cb      = (rem_b < room) ? rem_b : room;
         ch.len  = 10'((cb / 4) % 1024);
         ch.addr = addr_b;
         ch.bc   = 12'(rem_b % 4096);
         ch.la   = 7'(addr_b % 128);
         mq.push_back(ch);
         addr_b += longint'(cb);
         rem_b  -= cb;
      end
   endtask

   task automatic pin(input int idx, input logic [9:0] len, input logic [63:0] addr,
                      input logic [11:0] bc, input logic [6:0] la);
      check("model len", mq[idx].len, len);
      check("model addr", mq[idx].addr, addr);
      check("model bc", mq[idx].bc, bc);
      check("model la", mq[idx].la, la);
   endtask

   always begin
      @(posedge clk);
      #1;
      cyc++;
      check("rd_en", o_rd_en, 64'(cyc == exp_rd_cyc));
      check("done", o_done, 64'(cyc == exp_done_cyc));
      if (o_rd_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected chunk", 1, 0);
         end else begin
            cc = exp_q.pop_front();
            check("rd_length", o_rd_length, cc.len);
            check("rd_addr", o_rd_addr, cc.addr);
            check("byte_count", o_cpl_byte_count, cc.bc);
            check("lower_addr", o_cpl_lower_addr, cc.la);
            check("tag", o_cpl_tag, cur_tag);
         end
      end
      if (chk_hs) begin
         exp_busy = (cyc > acc_cyc) && (cyc < end_cyc);
         check("busy", o_busy, exp_busy);
         check("req_ready", o_req_ready, !exp_busy);
      end
   end

   task automatic run_req(input logic [63:0] a, input logic [9:0] l, input logic [7:0] tag,
                          input logic [2:0] code, input bit hold_valid, input bit early_last,
                          input int start_gap, input bit abort);
      int n;
      int t;
      build(a, l, code);
      foreach (mq[k]) exp_q.push_back(mq[k]);
      @(negedge clk);
      i_req_valid   = 1'b1;
      i_req_addr    = a;
      i_req_length  = l;
      i_req_tag     = tag;
      i_max_payload = code;
      n = 0;
      while (!o_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("accept timeout", 0, 1);
         i_req_valid = 1'b0;
         exp_q.delete();
         return;
      end
      cur_tag    = tag;
      acc_cyc    = cyc;
      end_cyc    = NEVER;
      exp_rd_cyc = cyc + 2;
      if (!hold_valid) begin
         @(negedge clk);
         i_req_valid = 1'b0;
         i_req_addr  = ~64'd0;
         i_req_tag   = ~tag;
      end
      for (int k = 0; k < mq.size(); k++) begin
         while (cyc < exp_rd_cyc) @(negedge clk);
         @(negedge clk);
         if (early_last) begin
            i_last_data = 1'b1;
            @(negedge clk);
            i_last_data = 1'b0;
         end
         repeat (start_gap) @(negedge clk);
         i_gen_tlp_start = 1'b1;
         @(negedge clk);
         i_gen_tlp_start = 1'b0;
         if (abort) begin
            @(negedge clk);
            rst_n = 1'b0;
            exp_rd_cyc   = -1;
            exp_done_cyc = -1;
            chk_hs       = 1'b0;
            exp_q.delete();
            i_req_valid  = 1'b0;
            #1;
            check("rst rd_en", o_rd_en, 0);
            check("rst done", o_done, 0);
            check("rst busy", o_busy, 0);
            check("rst ready", o_req_ready, 0);
            check("rst rd_length", o_rd_length, 0);
            check("rst rd_addr", o_rd_addr, 0);
            check("rst byte_count", o_cpl_byte_count, 0);
            check("rst lower_addr", o_cpl_lower_addr, 0);
            check("rst tag", o_cpl_tag, 0);
            return;
         end
         i_last_data = 1'b1;
         t = cyc;
         if (k == mq.size() - 1) begin
            exp_done_cyc = t + 1;
            end_cyc      = t + 1;
            i_req_valid  = 1'b0;
         end else begin
            exp_rd_cyc = t + 2;
         end
         @(negedge clk);
         i_last_data = 1'b0;
      end
      while (cyc <= exp_done_cyc) @(negedge clk);
      check("chunks left", exp_q.size(), 0);
   endtask

   initial begin
      #4000000;
      $display("FAIL global timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("reset rd_en", o_rd_en, 0);
      check("reset ready", o_req_ready, 0);
      check("reset busy", o_busy, 0);
      check("reset rd_addr", o_rd_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready after reset", o_req_ready, 1);
      chk_hs = 1'b1;

      build(64'h1000, 10'd16, 3'd0);
      check("model single n", mq.size(), 1);
      pin(0, 10'd16, 64'h1000, 12'd64, 7'h00);
      run_req(64'h1000, 10'd16, 8'h11, 3'd0, 1'b0, 1'b0, 0, 1'b0);

      build(64'h1F0, 10'd64, 3'd0);
      check("model split n", mq.size(), 3);
      pin(0, 10'd4, 64'h1F0, 12'd256, 7'h70);
      pin(1, 10'd32, 64'h200, 12'd240, 7'h00);
      pin(2, 10'd28, 64'h280, 12'd112, 7'h00);
      run_req(64'h1F3, 10'd64, 8'h22, 3'd0, 1'b0, 1'b1, 2, 1'b0);

      build(64'h0, 10'd0, 3'd7);
      check("model max n", mq.size(), 1);
      pin(0, 10'd0, 64'h0, 12'd0, 7'h00);
      run_req(64'h0, 10'd0, 8'h33, 3'd7, 1'b0, 1'b0, 1, 1'b0);

      build(64'hF80, 10'd96, 3'd1);
      check("model mps1 n", mq.size(), 2);
      pin(0, 10'd32, 64'hF80, 12'd384, 7'h00);
      pin(1, 10'd64, 64'h1000, 12'd256, 7'h00);
      run_req(64'hF80, 10'd96, 8'h44, 3'd1, 1'b1, 1'b0, 0, 1'b0);

      run_req(64'hFFFF_FFFF_FFFF_FF00, 10'd40, 8'h5A, 3'd0, 1'b0, 1'b0, 0, 1'b0);

      run_req(64'h2000, 10'd32, 8'h66, 3'd0, 1'b0, 1'b0, 0, 1'b1);
      repeat (2) @(negedge clk);
      check("held in reset ready", o_req_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready after mid reset", o_req_ready, 1);
      acc_cyc = -1;
      end_cyc = -1;
      chk_hs  = 1'b1;

      build(64'h3F8, 10'd10, 3'd2);
      check("model post-reset n", mq.size(), 2);
      pin(0, 10'd2, 64'h3F8, 12'd40, 7'h78);
      pin(1, 10'd8, 64'h400, 12'd32, 7'h00);
      run_req(64'h3F8, 10'd10, 8'h77, 3'd2, 1'b0, 1'b0, 0, 1'b0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
